data_buffer_rx_param: RTL

// - Parametrised successor RX data FIFO for the USB endpoint path. The RX packet

---
 rtl/data_buffer_rx_param.sv | 123 ++++++++++++
 1 files changed

// File: rtl/data_buffer_rx_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_buffer_rx_param: parametrised RX word FIFO with registered read      |
// | path and sticky error flags. Optional almost_full via                     |
// | DATA_BUFFER_RX_WATERMARK_EN.                                              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module data_buffer_rx_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int WMARK  = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     store_rx_packet_data,
  input  logic [DATA_W-1:0]        rx_packet_data,
  input  logic                     get_rx_data,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rx_data_valid,
  output logic [$clog2(DEPTH):0]   buffer_occupancy_rx,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow_err,
  output logic                     underflow_err,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
    $error("data_buffer_rx_param: DATA_W must be a multiple of 8, >= 8");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("data_buffer_rx_param: DEPTH must be a power of 2, >= 2");
  end
  if ((WMARK < 0) || (WMARK > DEPTH)) begin : g_bad_wmark
    $error("data_buffer_rx_param: WMARK must lie in 0..DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       occ_next;
  logic              pop_ok;
  logic              push_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = get_rx_data && !empty;
  assign push_ok = store_rx_packet_data && (!full || pop_ok);

  always_comb begin
    occ_next = buffer_occupancy_rx;
    if (push_ok && !pop_ok) begin
      occ_next = buffer_occupancy_rx + PTR_ONE;
    end else if (!push_ok && pop_ok) begin
      occ_next = buffer_occupancy_rx - PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst && !flush && push_ok) begin
      mem[wr_ptr[AW-1:0]] <= rx_packet_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      buffer_occupancy_rx <= '0;
      rx_data             <= '0;
      rx_data_valid       <= 1'b0;
      overflow_err        <= 1'b0;
      underflow_err       <= 1'b0;
    end else if (flush) begin
      // rx_data deliberately holds across a flush.
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      buffer_occupancy_rx <= '0;
      rx_data_valid       <= 1'b0;
      overflow_err        <= 1'b0;
      underflow_err       <= 1'b0;
    end else begin
      rx_data_valid       <= pop_ok;
      buffer_occupancy_rx <= occ_next;
      if (pop_ok) begin
        rx_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (store_rx_packet_data && !push_ok) begin
        overflow_err <= 1'b1;
      end
      if (get_rx_data && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

`ifdef DATA_BUFFER_RX_WATERMARK_EN
  localparam logic [AW:0] WMARK_C = (AW+1)'(WMARK);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      almost_full <= 1'b0;
    end else if (flush) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (occ_next >= WMARK_C);
    end
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule
`default_nettype wire
